// File: rtl/mul_8bits_seq_pkg.sv
// mul_8bits_seq_pkg: shared widths and FSM state encoding for the sequential multiplier.
package mul_8bits_seq_pkg;
   localparam int MUL_W     = 8;
   localparam int MUL_STEPS = 8;
   localparam int MUL_CNT_W = 3;
   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/mul_8bits_seq_adder.sv
// adder_8bits: 8-bit ripple adder used as the multiplier's add stage.
module adder_8bits
   import mul_8bits_seq_pkg::*;
(
   input  logic [MUL_W-1:0] a,
   input  logic [MUL_W-1:0] b,
   input  logic             ci,
   output logic [MUL_W-1:0] s,
   output logic             co
);
   assign {co, s} = a + b + {{(MUL_W-1){1'b0}}, ci};
endmodule

// File: rtl/mul_8bits_seq.sv
// mul_8bits_seq: sequential shift-and-add 8x8 unsigned multiplier with start/done handshake.
// Define MUL_ZERO_BYPASS_EN to finish zero-operand requests in one cycle without entering RUN.
module mul_8bits_seq
   import mul_8bits_seq_pkg::*;
#(
   parameter int WIDTH = MUL_W,
   parameter int CNT_W = MUL_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   state_e             state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d, acc_q, acc_d, q_q, q_d, addend, sum;
   logic               co;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               busy_q, busy_d, done_q, done_d;

   assign addend = q_q[0] ? m_q : '0;

   adder_8bits u_add (.a(acc_q), .b(addend), .ci(1'b0), .s(sum), .co(co));

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      case (state_q)
         MUL_IDLE: if (start) begin
            m_d     = a;
            q_d     = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = MUL_RUN;
`ifdef MUL_ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
               state_d = MUL_DONE;
               prod_d  = '0;
            end
`endif
         end
         MUL_RUN: begin
            // carry-out shifts into the top of A, so no partial-product bit is lost
            acc_d = {co, sum[WIDTH-1:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               state_d = MUL_DONE;
               prod_d  = {co, sum, q_q[WIDTH-1:1]};
            end
         end
         default: state_d = MUL_IDLE;
      endcase
      busy_d = (state_d == MUL_RUN);
      done_d = (state_d == MUL_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MUL_IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = prod_q;
endmodule

// File: tb/tb_mul_8bits_seq.sv
// tb_mul_8bits_seq: randomized self-checking bench for mul_8bits_seq against plain a*b.
// Expected zero-operand latency follows MUL_ZERO_BYPASS_EN.
module tb_mul_8bits_seq;
`ifdef MUL_ZERO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  a = '0, b = '0;
   logic        busy, done;
   logic [15:0] product;
   int          total = 0, bad = 0;

   mul_8bits_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Call at a negedge with the DUT idle; returns at the negedge after the cycle following done.
   task automatic op(input logic [7:0] x, input logic [7:0] y, input bit hold);
      int          cyc;
      bit          byp;
      logic [15:0] exp_p;
      exp_p = 16'(x) * 16'(y);
      byp   = BYPASS && (x == 0 || y == 0);
      a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1;
      if (hold) begin
         a = 8'd3; b = 8'd3;
      end else begin
         start = 1'b0;
         a = 8'($urandom); b = 8'($urandom);
      end
      cyc = 0;
      @(negedge clk);
      while (!done && cyc < 20) begin
         chk("busy_run", 32'(busy), 32'(!byp));
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, byp ? 0 : 8);
      chk("product", 32'(product), 32'(exp_p));
      chk("busy_at_done", 32'(busy), 0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 0);
      chk("product_hold", 32'(product), 32'(exp_p));
   endtask

   initial begin
      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_product", 32'(product), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op(8'd13, 8'd11, 1'b0);
      op(8'd255, 8'd255, 1'b0);
      op(8'd0, 8'd200, 1'b0);
      op(8'd200, 8'd0, 1'b0);
      op(8'd7, 8'd9, 1'b1);
      op(8'd3, 8'd3, 1'b0);
      // abort at RUN step 4
      a = 8'd100; b = 8'd100; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_product", 32'(product), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_still_idle", 32'(done | busy), 0);
      op(8'd100, 8'd100, 1'b0);
      for (int i = 0; i < 500; i++) op(8'($urandom), 8'($urandom), 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
